local_predictor: RTL and testbench

- Local-history direction predictor for an Alpha 21264-style tournament branch predictor.
- Consumes the 10-bit per-branch local history supplied by the local history table (LHT) as an index into a 1024-entry table of 3-bit saturating counters.
- Produces a registered taken/not-taken prediction and trains the indexed counter with the resolved branch outcome.
- Sits between the LHT and the choice predictor / final prediction mux.

---
 rtl/bp_pkg.sv | 16 +
 rtl/sat_counter.sv | 23 ++
 rtl/local_predictor.sv | 45 ++++
 tb/tb_local_predictor.sv | 129 ++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the tournament branch predictor.
//   HIST_W   : local-history / table index width
//   CTR_W    : saturating counter width
//   CTR_INIT : counter reset value (weakly not-taken)
//   LP_DEPTH : number of local predictor table entries (2**HIST_W)
package bp_pkg;

    localparam int unsigned HIST_W   = 10;
    localparam int unsigned CTR_W    = 3;
    localparam int unsigned LP_DEPTH = 1 << HIST_W;
    localparam logic [CTR_W-1:0] CTR_INIT = 3'b011;

    typedef logic [CTR_W-1:0]  ctr_t;
    typedef logic [HIST_W-1:0] lhist_t;

endpackage

// File: rtl/sat_counter.sv
// Combinational next-value logic for a CTR_W-bit saturating counter.
// Ports:
//   cur   : current counter value
//   taken : 1 = increment toward all-ones, 0 = decrement toward zero
//   nxt   : saturated next value
module sat_counter
    import bp_pkg::*;
(
    input  ctr_t cur,
    input  logic taken,
    output ctr_t nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != '1) nxt = cur + ctr_t'(1);
        end else begin
            if (cur != '0) nxt = cur - ctr_t'(1);
        end
    end

endmodule

// File: rtl/local_predictor.sv
// Local-history direction predictor: the LHT-supplied history indexes a
// table of saturating counters. Every non-reset edge registers the MSB of
// the indexed counter (value before this edge's update) as the prediction
// and trains that same counter with the resolved outcome.
// Ports:
//   clock       : system clock, all updates on posedge
//   reset       : synchronous active-high reset (counters -> CTR_INIT)
//   BranchTaken : resolved outcome for training, 1 = taken
//   LHTresult   : local history, selects the counter entry
//   LPresult    : registered prediction, 1 = predict taken
module local_predictor
    import bp_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              BranchTaken,
    input  logic [HIST_W-1:0] LHTresult,
    output logic              LPresult
);

    ctr_t ctr [LP_DEPTH];
    ctr_t cur_ctr;
    ctr_t nxt_ctr;

    assign cur_ctr = ctr[LHTresult];

    sat_counter u_sat (
        .cur   (cur_ctr),
        .taken (BranchTaken),
        .nxt   (nxt_ctr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < LP_DEPTH; i++) begin
                ctr[i] <= CTR_INIT;
            end
            LPresult <= 1'b0;
        end else begin
            LPresult       <= cur_ctr[CTR_W-1];
            ctr[LHTresult] <= nxt_ctr;
        end
    end

endmodule

// File: tb/tb_local_predictor.sv
module tb_local_predictor;

    logic       clock;
    logic       reset;
    logic       BranchTaken;
    logic [9:0] LHTresult;
    logic       LPresult;

    int errors = 0;
    int checks = 0;

    // Reference model: plain integers 0..7 per entry, plus the expected output.
    int model_ctr [1024];
    int model_lp;

    local_predictor dut (
        .clock       (clock),
        .reset       (reset),
        .BranchTaken (BranchTaken),
        .LHTresult   (LHTresult),
        .LPresult    (LPresult)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) model_ctr[i] = 3;
        model_lp = 0;
    endtask

    // Apply one cycle of stimulus, advance the model, then compare after the edge.
    task automatic cyc(input string tag, input logic rst, input int idx, input logic tk);
        reset       = rst;
        LHTresult   = 10'(idx);
        BranchTaken = tk;
        @(posedge clock);
        if (rst) begin
            model_reset();
        end else begin
            model_lp = (model_ctr[idx] >= 4) ? 1 : 0;
            if (tk) model_ctr[idx] = (model_ctr[idx] == 7) ? 7 : model_ctr[idx] + 1;
            else    model_ctr[idx] = (model_ctr[idx] == 0) ? 0 : model_ctr[idx] - 1;
        end
        #1;
        check(tag, int'(LPresult), model_lp);
    endtask

    initial begin
        int exp_seq [5];
        int pick [6];

        model_reset();
        reset = 1'b1; LHTresult = '0; BranchTaken = 1'b0;

        // 1: reset hold, then first two trainings at idx 5
        for (int i = 0; i < 16; i++) cyc("reset_hold", 1'b1, 5, 1'b1);
        check("reset_lp", int'(LPresult), 0);
        cyc("t1_edge1", 1'b0, 5, 1'b1);
        check("t1_edge1_abs", int'(LPresult), 0);
        cyc("t1_edge2", 1'b0, 5, 1'b1);
        check("t1_edge2_abs", int'(LPresult), 1);

        // 2: saturate high, no wrap
        for (int i = 0; i < 10; i++) begin
            cyc("t2_sat_hi", 1'b0, 5, 1'b1);
            check("t2_sat_hi_abs", int'(LPresult), 1);
        end

        // 3: walk down from 111: predictions 1,1,1,1,0 then floor at 000
        exp_seq = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            cyc("t3_down", 1'b0, 5, 1'b0);
            check("t3_down_abs", int'(LPresult), exp_seq[i]);
        end
        for (int i = 0; i < 6; i++) cyc("t3_sat_lo", 1'b0, 5, 1'b0);
        // From a floored 000, four taken edges read 000..011 -> all predict 0
        for (int i = 0; i < 4; i++) begin
            cyc("t3_climb", 1'b0, 5, 1'b1);
            check("t3_climb_abs", int'(LPresult), 0);
        end
        cyc("t3_climb5", 1'b0, 5, 1'b1);
        check("t3_climb5_abs", int'(LPresult), 1);

        // 4: untouched entry 1023 vs trained entry 5
        for (int i = 0; i < 4; i++) cyc("t4_train", 1'b0, 5, 1'b1);
        cyc("t4_idx1023", 1'b0, 1023, 1'b0);
        check("t4_idx1023_abs", int'(LPresult), 0);
        cyc("t4_idx5", 1'b0, 5, 1'b1);
        check("t4_idx5_abs", int'(LPresult), 1);

        // 5: alternation from 011 on a fresh index
        for (int i = 0; i < 8; i++) begin
            cyc("t5_alt", 1'b0, 77, (i % 2) == 0);
            check("t5_alt_abs", int'(LPresult), i % 2);
        end

        // 6: saturate 5 and 700, reset one cycle, then both read back as not-taken
        for (int i = 0; i < 6; i++) begin
            cyc("t6_sat5", 1'b0, 5, 1'b1);
            cyc("t6_sat700", 1'b0, 700, 1'b1);
        end
        cyc("t6_reset", 1'b1, 700, 1'b1);
        check("t6_reset_abs", int'(LPresult), 0);
        cyc("t6_read5", 1'b0, 5, 1'b0);
        check("t6_read5_abs", int'(LPresult), 0);
        cyc("t6_read700", 1'b0, 700, 1'b0);
        check("t6_read700_abs", int'(LPresult), 0);

        // Random traffic over a small index set so entries get revisited
        pick = '{0, 5, 700, 1023, 512, 333};
        for (int i = 0; i < 3000; i++) begin
            cyc("rand", ($urandom_range(0, 199) == 0),
                pick[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
